// File: rtl/turn_signal_ctrl.sv
// Turn-signal request controller.
// Synchronizes and debounces the left/right stalk contacts and the hazard
// push-button, turns the hazard button into a press-to-toggle mode, and
// produces registered left/right requests plus a free-running step strobe
// for the downstream tail-light sequencer.
module turn_signal_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int TICK_DIV   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic hazard_btn,
    output logic left,
    output logic right,
    output logic hazard_on,
    output logic step
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Bit positions shared by all per-input vectors.
    localparam int IDX_L = 0;
    localparam int IDX_R = 1;
    localparam int IDX_H = 2;

    logic [2:0]    raw_s;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    deb_q;
    logic [2:0]    deb_d;
    logic [CW-1:0] cnt_q [0:2];
    logic [CW-1:0] cnt_d [0:2];

    logic          hz_prev_q;
    logic          hazard_q;
    logic          hazard_d;
    logic          left_q;
    logic          right_q;
    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          step_q;
    logic          step_d;

    assign raw_s = {hazard_btn, right_sw, left_sw};

    // Two-flop synchronizers for the three raw contacts.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive mismatches.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounced levels and their stability counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Hazard mode flips once per accepted press; releases are ignored.
    always_comb begin
        if (deb_q[IDX_H] && !hz_prev_q) begin
            hazard_d = ~hazard_q;
        end else begin
            hazard_d = hazard_q;
        end
    end

    // Hazard edge detector, hazard mode and the left/right request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hz_prev_q <= 1'b0;
            hazard_q  <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            hz_prev_q <= deb_q[IDX_H];
            hazard_q  <= hazard_d;
            left_q    <= deb_q[IDX_L] | hazard_q;
            right_q   <= deb_q[IDX_R] | hazard_q;
        end
    end

    // Step interval counter; the strobe is decoded from the next count so it
    // is registered yet lines up with the cycle in which tcnt is at its top.
    always_comb begin
        if (tcnt_q == TICK_LAST) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
        step_d = (tcnt_d == TICK_LAST);
    end

    // Free-running step counter and strobe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            step_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            step_q <= step_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign hazard_on = hazard_q;
    assign step      = step_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Self-checking bench for turn_signal_ctrl with a sample-history reference model.
module tb_turn_signal_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 8;

    logic clk = 1'b0;
    logic reset;
    logic left_sw;
    logic right_sw;
    logic hazard_btn;
    logic left;
    logic right;
    logic hazard_on;
    logic step;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw history per input (index 0 = newest sample).
    bit hist [0:2][0:DEB];
    bit m_d [0:2];
    bit m_hz, m_hprev, m_left, m_right, m_step;
    int m_n;

    turn_signal_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .left_sw    (left_sw),
        .right_sw   (right_sw),
        .hazard_btn (hazard_btn),
        .left       (left),
        .right      (right),
        .hazard_on  (hazard_on),
        .step       (step)
    );

    always #5 clk = ~clk;

    // Model of one rising edge. A debounced level flips when the synchronized
    // samples seen at the last DEB edges (raw taken 2 edges earlier) all differ from it.
    task automatic model_edge(input bit [2:0] raw, input bit rst);
        bit nl, nr, nh, all_diff;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_d[i] = 1'b0;
                for (int j = 0; j <= DEB; j++) hist[i][j] = 1'b0;
            end
            m_hz = 0; m_hprev = 0; m_left = 0; m_right = 0; m_step = 0; m_n = 0;
        end else begin
            nl = m_d[0] | m_hz;
            nr = m_d[1] | m_hz;
            nh = m_hz ^ (m_d[2] & ~m_hprev);
            m_hprev = m_d[2];
            for (int i = 0; i < 3; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[i][j] == m_d[i]) all_diff = 1'b0;
                if (all_diff) m_d[i] = ~m_d[i];
                for (int j = DEB; j >= 1; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = raw[i];
            end
            m_left = nl; m_right = nr; m_hz = nh;
            m_n++;
            m_step = ((m_n % TDIV) == TDIV - 1);
        end
    endtask

    task automatic cyc(input bit l, input bit r, input bit h, input bit rst);
        left_sw = l; right_sw = r; hazard_btn = h; reset = rst;
        @(posedge clk);
        model_edge({h, r, l}, rst);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
            checks++;
            if ({left, right, hazard_on, step} !== 4'b0000) begin
                errors++;
                $display("FAIL reset cyc %0d got %b exp 0000", k, {left, right, hazard_on, step});
            end
        end
    endtask

    task automatic test_latency();
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0, 0);
            checks++;
            if ({left, right, hazard_on} !== {(k >= DEB + 3), 2'b00}) begin
                errors++;
                $display("FAIL latency edge %0d got %b exp %b", k, {left, right, hazard_on}, {(k >= DEB + 3), 2'b00});
            end
        end
    endtask

    task automatic test_bounce();
        int k;
        cyc(0, 0, 0, 1);
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 6; c++) begin
                cyc(c < 3, 0, 0, 0);
                checks++;
                if (left !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce pulse %0d cyc %0d got %b exp 0", p, c, left);
                end
            end
        end
        for (k = 1; k <= 10; k++) begin
            cyc(1, 0, 0, 0);
            checks++;
            if (left !== (k >= DEB + 3)) begin
                errors++;
                $display("FAIL bounce_hold edge %0d got %b exp %b", k, left, (k >= DEB + 3));
            end
        end
    endtask

    task automatic test_hazard();
        bit saw_on = 1'b0;
        cyc(0, 0, 0, 1);
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < ((ph % 2 == 0) ? 6 : 12); c++) begin
                cyc(0, 0, (ph % 2 == 0), 0);
                if (hazard_on) saw_on = 1'b1;
                checks++;
                if ({left, right, hazard_on, step} !== {m_left, m_right, m_hz, m_step}) begin
                    errors++;
                    $display("FAIL hazard ph %0d cyc %0d got %b exp %b", ph, c,
                             {left, right, hazard_on, step}, {m_left, m_right, m_hz, m_step});
                end
            end
        end
        checks++;
        if ({saw_on, hazard_on, left, right} !== 4'b1000) begin
            errors++;
            $display("FAIL hazard_toggle got saw/hz/l/r %b exp 1000", {saw_on, hazard_on, left, right});
        end
    endtask

    task automatic test_both();
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 1, 0, 0);
            checks++;
            if ({left, right} !== {2{k >= DEB + 3}}) begin
                errors++;
                $display("FAIL both edge %0d got %b exp %b", k, {left, right}, {2{k >= DEB + 3}});
            end
        end
    endtask

    task automatic test_step();
        int n = 0;
        bit rst;
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 40; k++) begin
            rst = (k == 20);
            cyc(0, 0, 0, rst);
            n = rst ? 0 : n + 1;
            checks++;
            if (step !== ((n % TDIV) == TDIV - 1)) begin
                errors++;
                $display("FAIL step cyc %0d got %b exp %b", k, step, ((n % TDIV) == TDIV - 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 0, 0, 0);
            checks++;
            if (left !== (k >= DEB + 3)) begin
                errors++;
                $display("FAIL reset_mid edge %0d got %b exp %b", k, left, (k >= DEB + 3));
            end
        end
    endtask

    task automatic test_random();
        bit [2:0] raw = 3'b000;
        int hold = 0;
        bit rst;
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                raw[$urandom_range(0, 2)] ^= 1'b1;
                hold = $urandom_range(1, 9);
            end
            hold--;
            rst = ($urandom_range(0, 199) == 0);
            cyc(raw[0], raw[1], raw[2], rst);
            checks++;
            if ({left, right, hazard_on, step} !== {m_left, m_right, m_hz, m_step}) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", k,
                         {left, right, hazard_on, step}, {m_left, m_right, m_hz, m_step});
            end
        end
    endtask

    initial begin
        reset = 1'b1; left_sw = 1'b0; right_sw = 1'b0; hazard_btn = 1'b0;
        test_reset();
        test_latency();
        test_bounce();
        test_hazard();
        test_both();
        test_step();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
